// File: rtl/kyo_sprite_pkg.sv
// Shared constants and types for the Kyo sprite fetch stage.
// Sprite geometry, animation timing and the transparent palette key live here.
package kyo_sprite_pkg;

  localparam int SPR_W      = 64;
  localparam int SPR_H      = 96;
  localparam int FRAMES     = 4;
  localparam int HOLD       = 6;
  localparam int ADDR_W     = 15;
  localparam int FRAME_SIZE = SPR_W * SPR_H;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } anim_state_t;

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

endpackage

// File: rtl/kyo_anim_ctrl.sv
// Kick animation sequencer: steps through FRAMES frames, each held for HOLD vsync periods.
// frame_next exposes the value frame_num takes on the coming edge for the shadow latch.
module kyo_anim_ctrl
  import kyo_sprite_pkg::*;
#(
  parameter int FRAMES_P = FRAMES,
  parameter int HOLD_P   = HOLD,
  parameter int FW       = (FRAMES_P > 1) ? $clog2(FRAMES_P) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync_start,
  input  logic          kick_req,
  output logic          busy,
  output logic [FW-1:0] frame_num,
  output logic [FW-1:0] frame_next,
  output anim_state_t   state
);

  localparam int HW = (HOLD_P > 1) ? $clog2(HOLD_P) : 1;

  logic [HW-1:0] hold_cnt;
  logic          hold_done;

  assign hold_done = (state == PLAY) && vsync_start && (hold_cnt == HW'(HOLD_P - 1));

  always_comb begin
    frame_next = frame_num;
    if (hold_done) begin
      frame_next = (frame_num == FW'(FRAMES_P - 1)) ? '0 : frame_num + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      hold_cnt  <= '0;
      frame_num <= '0;
    end else begin
      case (state)
        IDLE: begin
          hold_cnt  <= '0;
          frame_num <= '0;
          // A vsync coinciding with the kick does not count toward the first hold.
          if (kick_req) begin
            state <= PLAY;
            busy  <= 1'b1;
          end
        end
        PLAY: begin
          frame_num <= frame_next;
          if (vsync_start) begin
            if (hold_done) begin
              hold_cnt <= '0;
              if (frame_num == FW'(FRAMES_P - 1)) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/kyo_sprite_fetch.sv
// Per-pixel sprite box hit test and ROM address generation, with a 3-stage
// pipeline that realigns synchronous ROM data with the hit flag.
module kyo_sprite_fetch
  import kyo_sprite_pkg::*;
#(
  parameter int SPR_W_P  = SPR_W,
  parameter int SPR_H_P  = SPR_H,
  parameter int FRAMES_P = FRAMES,
  parameter int HOLD_P   = HOLD,
  parameter int ADDR_W_P = ADDR_W,
  parameter int FW       = (FRAMES_P > 1) ? $clog2(FRAMES_P) : 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                vsync_start,
  input  logic                kick_req,
  input  logic [9:0]          sprite_x,
  input  logic [9:0]          sprite_y,
  input  logic                facing_left,
  input  logic [9:0]          drawX,
  input  logic [9:0]          drawY,
  output logic [ADDR_W_P-1:0] rom_addr,
  input  logic [3:0]          rom_data,
  output logic [3:0]          pixel_index,
  output logic                pixel_opaque,
  output logic                busy,
  output logic [FW-1:0]       frame_num,
  output anim_state_t         anim_state
);

  localparam int CW = $clog2(SPR_W_P);

  logic [9:0]          disp_x, disp_y;
  logic                disp_facing;
  logic [FW-1:0]       disp_frame;
  logic [FW-1:0]       frame_next;
  logic [10:0]         x_end, y_end;
  logic                hit;
  logic [9:0]          rel_x, rel_y;
  logic [CW-1:0]       col;
  logic [ADDR_W_P-1:0] addr;
  logic                hit_d1, hit_d2;
  logic                opaque;

  kyo_anim_ctrl #(
    .FRAMES_P (FRAMES_P),
    .HOLD_P   (HOLD_P),
    .FW       (FW)
  ) u_anim (
    .clk         (Clk),
    .rst_n       (Reset_n),
    .vsync_start (vsync_start),
    .kick_req    (kick_req),
    .busy        (busy),
    .frame_num   (frame_num),
    .frame_next  (frame_next),
    .state       (anim_state)
  );

  // Shadow copies change only at vsync so a frame never shows a half-moved sprite.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      disp_x      <= '0;
      disp_y      <= '0;
      disp_facing <= 1'b0;
      disp_frame  <= '0;
    end else if (vsync_start) begin
      disp_x      <= sprite_x;
      disp_y      <= sprite_y;
      disp_facing <= facing_left;
      disp_frame  <= frame_next;
    end
  end

  // 11-bit bounds so a box hanging past column/row 1023 clips instead of wrapping.
  assign x_end = {1'b0, disp_x} + 11'(SPR_W_P);
  assign y_end = {1'b0, disp_y} + 11'(SPR_H_P);
  assign hit   = (drawX >= disp_x) && ({1'b0, drawX} < x_end) &&
                 (drawY >= disp_y) && ({1'b0, drawY} < y_end);

  assign rel_x = drawX - disp_x;
  assign rel_y = drawY - disp_y;
  assign col   = disp_facing ? ~rel_x[CW-1:0] : rel_x[CW-1:0];
  assign addr  = ADDR_W_P'(disp_frame) * ADDR_W_P'(SPR_W_P * SPR_H_P)
               + ADDR_W_P'(rel_y) * ADDR_W_P'(SPR_W_P)
               + ADDR_W_P'(col);

  assign opaque = hit_d2 && (rom_data != TRANSPARENT_IDX);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr     <= '0;
      hit_d1       <= 1'b0;
      hit_d2       <= 1'b0;
      pixel_opaque <= 1'b0;
      pixel_index  <= '0;
    end else begin
      rom_addr     <= hit ? addr : '0;
      hit_d1       <= hit;
      hit_d2       <= hit_d1;
      pixel_opaque <= opaque;
      pixel_index  <= opaque ? rom_data : TRANSPARENT_IDX;
    end
  end

endmodule
